// File: rtl/viterbi_depunct_feeder_pkg.sv
// Shared types and puncture-pattern tables for the Viterbi depuncturing feeder.
// VITERBI_FEEDER_RATE56_EN adds the 5/6 pattern; without it rate 3 decodes as 1/2.
package viterbi_feeder_pkg;

    typedef enum logic [1:0] {
        RATE_1_2 = 2'd0,
        RATE_2_3 = 2'd1,
        RATE_3_4 = 2'd2,
        RATE_5_6 = 2'd3
    } rate_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned PHASE_W = 3;

    function automatic logic [PHASE_W-1:0] pattern_len(input rate_e r);
        case (r)
            RATE_2_3: return 3'd2;
            RATE_3_4: return 3'd3;
`ifdef VITERBI_FEEDER_RATE56_EN
            RATE_5_6: return 3'd5;
`endif
            default:  return 3'd1;
        endcase
    endfunction

    // Returns {need_a, need_b}; a cleared bit marks an erased position.
    function automatic logic [1:0] phase_needs(input rate_e r, input logic [PHASE_W-1:0] phase);
        case (r)
            RATE_2_3: return (phase == 3'd0) ? 2'b11 : 2'b10;
            RATE_3_4: begin
                case (phase)
                    3'd0:    return 2'b11;
                    3'd1:    return 2'b10;
                    default: return 2'b01;
                endcase
            end
`ifdef VITERBI_FEEDER_RATE56_EN
            RATE_5_6: begin
                case (phase)
                    3'd0:       return 2'b11;
                    3'd1, 3'd3: return 2'b10;
                    default:    return 2'b01;
                endcase
            end
`endif
            default:  return 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/viterbi_depunct_feeder_punct_pattern.sv
// Combinational puncture lookup: which samples the current phase needs and whether it is the last phase.
// VITERBI_FEEDER_RATE56_EN (via the package) enables the 5-phase 5/6 pattern.
module punct_pattern
    import viterbi_feeder_pkg::*;
(
    input  rate_e              rate,
    input  logic [PHASE_W-1:0] phase,
    output logic               need_a,
    output logic               need_b,
    output logic               phase_last
);

    always_comb begin
        {need_a, need_b} = phase_needs(rate, phase);
        phase_last       = (phase == (pattern_len(rate) - 3'd1));
    end

endmodule

// File: rtl/viterbi_depunct_feeder.sv
// Depunctures soft samples into (sym0, sym1) pairs with erasure flags, then appends a zero flush tail.
// Optional macro VITERBI_FEEDER_RATE56_EN enables rate 5/6 on rate = 3.
module viterbi_depunct_feeder
    import viterbi_feeder_pkg::*;
#(
    parameter int unsigned SOFT_W    = 3,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned FLUSH_LEN = 96
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        rate,
    input  logic [CNT_W-1:0]  num_pairs,
    input  logic              in_valid,
    input  logic [SOFT_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SOFT_W-1:0] out_sym0,
    output logic [SOFT_W-1:0] out_sym1,
    output logic              out_erase0,
    output logic              out_erase1,
    output logic              busy,
    output logic              done
);

    localparam int unsigned FLUSH_W = $clog2(FLUSH_LEN + 1);
    localparam logic [SOFT_W-1:0] ERASE_VAL = {1'b1, {(SOFT_W-1){1'b0}}};

    state_e             state;
    rate_e              rate_q;
    logic [CNT_W-1:0]   num_q;
    logic [CNT_W-1:0]   pair_cnt;
    logic [FLUSH_W-1:0] flush_cnt;
    logic [PHASE_W-1:0] phase;
    logic               slot;
    logic [SOFT_W-1:0]  hold;

    logic need_a;
    logic need_b;
    logic phase_last;
    logic out_free;
    logic in_fire;
    logic last_payload;

    punct_pattern u_pattern (
        .rate       (rate_q),
        .phase      (phase),
        .need_a     (need_a),
        .need_b     (need_b),
        .phase_last (phase_last)
    );

    assign out_free     = !out_valid || out_ready;
    assign in_ready     = (state == FILL) && out_free;
    assign in_fire      = in_valid && in_ready;
    assign last_payload = ((pair_cnt + 1'b1) == num_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            rate_q     <= RATE_1_2;
            num_q      <= '0;
            pair_cnt   <= '0;
            flush_cnt  <= '0;
            phase      <= '0;
            slot       <= 1'b0;
            hold       <= '0;
            out_valid  <= 1'b0;
            out_sym0   <= '0;
            out_sym1   <= '0;
            out_erase0 <= 1'b0;
            out_erase1 <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rate_q    <= rate_e'(rate);
                        num_q     <= num_pairs;
                        pair_cnt  <= '0;
                        flush_cnt <= '0;
                        phase     <= '0;
                        slot      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= (num_pairs == '0) ? FLUSH : FILL;
                    end
                end
                FILL: begin
                    if (out_valid && out_ready)
                        out_valid <= 1'b0;
                    if (in_fire) begin
                        if (need_a && need_b && !slot) begin
                            hold <= in_data;
                            slot <= 1'b1;
                        end else begin
                            out_valid  <= 1'b1;
                            out_sym0   <= !need_a ? ERASE_VAL : (need_b ? hold : in_data);
                            out_sym1   <= need_b ? in_data : ERASE_VAL;
                            out_erase0 <= !need_a;
                            out_erase1 <= !need_b;
                            slot       <= 1'b0;
                            phase      <= phase_last ? '0 : phase + 3'd1;
                            pair_cnt   <= pair_cnt + 1'b1;
                            if (last_payload)
                                state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // The register may still hold the final payload pair on entry; flush pairs queue behind it.
                    if (out_free) begin
                        if (flush_cnt != FLUSH_W'(FLUSH_LEN)) begin
                            out_valid  <= 1'b1;
                            out_sym0   <= '0;
                            out_sym1   <= '0;
                            out_erase0 <= 1'b0;
                            out_erase1 <= 1'b0;
                            flush_cnt  <= flush_cnt + 1'b1;
                        end else begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_depunct_feeder.sv
// Scoreboard bench for viterbi_depunct_feeder: directed frames push expected pairs, a monitor pops on handshake.
// Expected rate-3 results follow VITERBI_FEEDER_RATE56_EN when defined.
module tb_viterbi_depunct_feeder;

    localparam int unsigned SOFT_W    = 3;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned FLUSH_LEN = 96;
    localparam int unsigned PW        = 2 * SOFT_W + 2;
    localparam int          M         = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [1:0]        rate = '0;
    logic [CNT_W-1:0]  num_pairs = '0;
    logic              in_valid = 1'b0;
    logic [SOFT_W-1:0] in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [SOFT_W-1:0] out_sym0;
    logic [SOFT_W-1:0] out_sym1;
    logic              out_erase0;
    logic              out_erase1;
    logic              busy;
    logic              done;

    viterbi_depunct_feeder #(
        .SOFT_W    (SOFT_W),
        .CNT_W     (CNT_W),
        .FLUSH_LEN (FLUSH_LEN)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .rate       (rate),
        .num_pairs  (num_pairs),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sym0   (out_sym0),
        .out_sym1   (out_sym1),
        .out_erase0 (out_erase0),
        .out_erase1 (out_erase1),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int acc_cnt = 0;
    logic [PW-1:0]     exp_q[$];
    logic [SOFT_W-1:0] stim[0:19];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [PW-1:0] mkp(input int a, input int b, input bit e0, input bit e1);
        logic [SOFT_W-1:0] sa = SOFT_W'(a);
        logic [SOFT_W-1:0] sb = SOFT_W'(b);
        return {sa, sb, e0, e1};
    endfunction

    task automatic push_flush();
        for (int i = 0; i < int'(FLUSH_LEN); i++) exp_q.push_back(mkp(0, 0, 1'b0, 1'b0));
    endtask

    // Monitor: pop-and-compare on every handshake, and hold-stability while stalled.
    logic [PW-1:0] prev_pair;
    bit            hold_prev = 1'b0;
    always @(negedge clock) begin
        logic [PW-1:0] cur;
        logic [PW-1:0] e;
        cur = {out_sym0, out_sym1, out_erase0, out_erase1};
        if (reset) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_stable", 32'(cur), 32'(prev_pair));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pair: got %0h expected none at %0t", cur, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("pair", 32'(cur), 32'(e));
                    acc_cnt++;
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_pair = cur;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_syms"}, 32'({out_sym0, out_sym1, out_erase0, out_erase1}), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Entered and left at posedge + #1.
    task automatic run_frame(input logic [1:0] r, input int np, input int nsamp, input int rdy_mode,
                             input bit rand_valid, input int exp_cons, input bit exp_no_ready);
        int idx = 0;
        int cyc = 0;
        int dones = 0;
        bit saw_ready = 1'b0;
        rate      = r;
        num_pairs = CNT_W'(np);
        start     = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        while (dones == 0 && cyc < 3000) begin
            out_ready = (rdy_mode == 0) ? 1'b1 : (cyc % 2 == 0);
            if (idx < nsamp) begin
                in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                in_data  = stim[idx];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clock);
            if (in_ready) saw_ready = 1'b1;
            if (in_valid && in_ready) idx++;
            if (done) dones++;
            @(posedge clock); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("done_pulse", 32'(dones), 32'd1);
        check("samples_consumed", 32'(idx), 32'(exp_cons));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        if (exp_no_ready) check("in_ready_never", 32'(saw_ready), 32'd0);
        @(negedge clock);
        check("done_single", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        int cyc;
        int idx;
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        check_all_zero("reset");
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        // Rate 1/2
        stim[0] = 0; stim[1] = 7; stim[2] = 7; stim[3] = 0;
        stim[4] = 3; stim[5] = 4; stim[6] = 1; stim[7] = 6;
        exp_q.push_back(mkp(0, 7, 0, 0));
        exp_q.push_back(mkp(7, 0, 0, 0));
        exp_q.push_back(mkp(3, 4, 0, 0));
        exp_q.push_back(mkp(1, 6, 0, 0));
        push_flush();
        run_frame(2'd0, 4, 8, 0, 1'b0, 8, 1'b0);

        // Rate 3/4
        for (int i = 0; i < 8; i++) stim[i] = SOFT_W'(i + 1);
        exp_q.push_back(mkp(1, 2, 0, 0));
        exp_q.push_back(mkp(3, M, 0, 1));
        exp_q.push_back(mkp(M, 4, 1, 0));
        exp_q.push_back(mkp(5, 6, 0, 0));
        exp_q.push_back(mkp(7, M, 0, 1));
        exp_q.push_back(mkp(M, 0, 1, 0));
        push_flush();
        run_frame(2'd2, 6, 8, 0, 1'b0, 8, 1'b0);

        // Rate 2/3 with toggling out_ready and random in_valid
        stim[0] = 2; stim[1] = 5; stim[2] = 6; stim[3] = 1; stim[4] = 3;
        stim[5] = 7; stim[6] = 0; stim[7] = 4; stim[8] = 5;
        exp_q.push_back(mkp(2, 5, 0, 0));
        exp_q.push_back(mkp(6, M, 0, 1));
        exp_q.push_back(mkp(1, 3, 0, 0));
        exp_q.push_back(mkp(7, M, 0, 1));
        exp_q.push_back(mkp(0, 4, 0, 0));
        exp_q.push_back(mkp(5, M, 0, 1));
        push_flush();
        run_frame(2'd1, 6, 9, 1, 1'b1, 9, 1'b0);

        // num_pairs = 0: flush only, samples offered but never taken
        push_flush();
        run_frame(2'd0, 0, 2, 0, 1'b0, 0, 1'b1);

        // Reset after 3 pairs of a 10-pair frame
        for (int i = 0; i < 20; i++) stim[i] = SOFT_W'(i);
        for (int i = 0; i < 10; i++) exp_q.push_back(mkp(2 * i, 2 * i + 1, 0, 0));
        acc_cnt   = 0;
        rate      = 2'd0;
        num_pairs = CNT_W'(10);
        start     = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 0;
        idx = 0;
        while (acc_cnt < 3 && cyc < 200) begin
            out_ready = 1'b1;
            in_valid  = (idx < 20);
            in_data   = stim[idx % 20];
            @(negedge clock); #1;
            if (in_valid && in_ready) idx++;
            @(posedge clock); #1;
            cyc++;
        end
        check("pairs_before_reset", 32'(acc_cnt), 32'd3);
        reset     = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clock);
        check_all_zero("abort");
        @(posedge clock); #1;
        stim[0] = 5; stim[1] = 2; stim[2] = 6; stim[3] = 3;
        exp_q.push_back(mkp(5, 2, 0, 0));
        exp_q.push_back(mkp(6, 3, 0, 0));
        push_flush();
        run_frame(2'd0, 2, 4, 0, 1'b0, 4, 1'b0);

        // rate = 3
        stim[0] = 1; stim[1] = 2; stim[2] = 3; stim[3] = 4; stim[4] = 5;
        stim[5] = 6; stim[6] = 7; stim[7] = 0; stim[8] = 1; stim[9] = 2;
`ifdef VITERBI_FEEDER_RATE56_EN
        exp_q.push_back(mkp(1, 2, 0, 0));
        exp_q.push_back(mkp(3, M, 0, 1));
        exp_q.push_back(mkp(M, 4, 1, 0));
        exp_q.push_back(mkp(5, M, 0, 1));
        exp_q.push_back(mkp(M, 6, 1, 0));
        push_flush();
        run_frame(2'd3, 5, 10, 0, 1'b0, 6, 1'b0);
`else
        exp_q.push_back(mkp(1, 2, 0, 0));
        exp_q.push_back(mkp(3, 4, 0, 0));
        exp_q.push_back(mkp(5, 6, 0, 0));
        exp_q.push_back(mkp(7, 0, 0, 0));
        exp_q.push_back(mkp(1, 2, 0, 0));
        push_flush();
        run_frame(2'd3, 5, 10, 0, 1'b0, 10, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
